pwl_event_sampler: RTL

PWL_EVENT_SAMPLER -- requirements
Module: pwl_event_sampler

---
 rtl/pwl_event_sampler.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/pwl_event_sampler.sv
`timescale 1ns/1ps
// Event-driven sampler: evaluates a piecewise-linear real input at each clock edge and
// queues {value, gap} whenever it moves by etol or the hold interval expires.

package pwl_pkg;
    typedef struct {
        real a;
        real b;
        real t0;
    } pwl;
endpackage : pwl_pkg

module pwl_event_sampler
    import pwl_pkg::*;
#(
    parameter real         etol     = 0.001,
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  pwl          in,
    input  logic        out_ready,
    output logic        out_valid,
    output real         out_val,
    output logic [15:0] out_gap,
    output logic        overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned GW = 16;
    localparam real         SEC_PER_UNIT = 1.0e-9;
    localparam logic [GW-1:0] HOLD_LAST = GW'(MAX_HOLD - 1);
    localparam logic [GW-1:0] GAP_MAX   = '1;

    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] rd_ptr_d;
    real           mem_val_q [DEPTH];
    logic [GW-1:0] mem_gap_q [DEPTH];
    real           last_q;
    logic [GW-1:0] hold_q;
    logic [GW-1:0] hold_inc_d;
    logic [GW-1:0] gap_d;
    logic          first_q;
    logic          out_valid_q;
    real           out_val_q;
    logic [GW-1:0] out_gap_q;
    logic          overflow_q;

    logic          empty_c;
    logic          full_c;
    logic          pop_c;
    logic          forced_c;
    logic          head_is_new_c;
    logic [AW-1:0] wr_idx_c;
    logic [AW-1:0] head_idx_c;

    // Time-independent next-state terms: pointers, forced refresh, gap of a capture.
    always_comb begin
        empty_c       = (wr_ptr_q == rd_ptr_q);
        full_c        = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop_c         = !empty_c && out_ready;
        forced_c      = first_q || (hold_q == HOLD_LAST);
        rd_ptr_d      = pop_c ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
        wr_idx_c      = wr_ptr_q[AW-1:0];
        head_idx_c    = rd_ptr_d[AW-1:0];
        head_is_new_c = (rd_ptr_d == wr_ptr_q);
        hold_inc_d    = (hold_q >= HOLD_LAST) ? HOLD_LAST : (hold_q + GW'(1));
        if (first_q) begin
            gap_d = '0;
        end else if (hold_q == GAP_MAX) begin
            gap_d = GAP_MAX;
        end else begin
            gap_d = hold_q + GW'(1);
        end
    end

    // The sample depends on simulation time at the edge itself, so it is evaluated
    // from inside the clocked process rather than from combinational logic.
    function automatic real sample_now();
        return in.a + in.b * (($realtime * SEC_PER_UNIT) - in.t0);
    endfunction

    function automatic logic capture_now();
        real delta;
        delta = sample_now() - last_q;
        return forced_c || (delta >= etol) || (-delta >= etol);
    endfunction

    function automatic logic push_now();
        return capture_now() && (!full_c || pop_c);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            last_q      <= 0.0;
            hold_q      <= '0;
            first_q     <= 1'b1;
            out_valid_q <= 1'b0;
            out_val_q   <= 0.0;
            out_gap_q   <= '0;
            overflow_q  <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            if (push_now()) begin
                mem_val_q[wr_idx_c] <= sample_now();
                mem_gap_q[wr_idx_c] <= gap_d;
                wr_ptr_q            <= wr_ptr_q + PW'(1);
                last_q              <= sample_now();
                hold_q              <= '0;
                first_q             <= 1'b0;
            end else if (capture_now()) begin
                // Dropped capture: leave last/hold alone so it retries next edge.
                overflow_q <= 1'b1;
            end else begin
                hold_q <= hold_inc_d;
            end

            out_valid_q <= push_now() || (rd_ptr_d != wr_ptr_q);
            if (push_now() && head_is_new_c) begin
                out_val_q <= sample_now();
                out_gap_q <= gap_d;
            end else begin
                out_val_q <= mem_val_q[head_idx_c];
                out_gap_q <= mem_gap_q[head_idx_c];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_val   = out_val_q;
    assign out_gap   = out_gap_q;
    assign overflow  = overflow_q;

endmodule : pwl_event_sampler
